board_gpio_bridge: RTL

//  Parametrised board I/O block between CPU bus and board switches/LEDs; successor to direct sw->gpio/gpio->led wiring.

---
 rtl/board_gpio_pkg.sv | 17 +
 rtl/gpio_debounce_cell.sv | 52 +++++
 rtl/board_gpio_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/board_gpio_pkg.sv
// Shared constants for the board GPIO bridge: register offsets, bus width and bus FSM states.
package board_gpio_pkg;

    localparam int BUS_W = 32;

    localparam logic [4:0] ADDR_IN   = 5'h00;
    localparam logic [4:0] ADDR_OUT  = 5'h04;
    localparam logic [4:0] ADDR_IEN  = 5'h08;
    localparam logic [4:0] ADDR_PEND = 5'h0C;
    localparam logic [4:0] ADDR_PWM  = 5'h10;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_READY = 1'b1
    } bus_state_t;

endpackage

// File: rtl/gpio_debounce_cell.sv
// One input bit: synchroniser chain, debounce counter, accepted level and a one-cycle change pulse.
module gpio_debounce_cell #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic stable_o,
    output logic edge_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   stable_q, stable_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sw_i};
        count_d  = '0;
        stable_d = stable_q;
        edge_o   = 1'b0;
        if (sync_bit != stable_q) begin
            // Accept only after the mismatch has persisted for the full window.
            if (count_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_bit;
                edge_o   = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            count_q  <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            count_q  <= count_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/board_gpio_bridge.sv
// Board I/O block: debounced inputs with edge interrupts, LED outputs and a small register bus.
// Optional PWM dimming of the outputs is enabled by defining BOARD_GPIO_PWM_EN.
module board_gpio_bridge
    import board_gpio_pkg::*;
#(
    parameter int N_IN            = 8,
    parameter int N_OUT           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int PWM_BITS        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bus_sel,
    input  logic             bus_write,
    input  logic [4:0]       bus_addr,
    input  logic [BUS_W-1:0] bus_wdata,
    output logic [BUS_W-1:0] bus_rdata,
    output logic             bus_ready,
    output logic             irq,
    input  logic [N_IN-1:0]  sw_in,
    output logic [N_OUT-1:0] led_out
);

    logic [N_IN-1:0]  stable, edge_det;
    bus_state_t       state_q, state_d;
    logic [BUS_W-1:0] rdata_q, rdata_d, rd_word;
    logic [N_OUT-1:0] out_q, out_d;
    logic [N_IN-1:0]  irq_en_q, irq_en_d;
    logic [N_IN-1:0]  pend_q, pend_d, pend_clr;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^bus_wdata;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        gpio_debounce_cell #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_i    (sw_in[i]),
            .stable_o(stable[i]),
            .edge_o  (edge_det[i])
        );
    end

`ifdef BOARD_GPIO_PWM_EN
    logic [PWM_BITS-1:0] cnt_q, cnt_d, duty_q, duty_d;
    logic [N_OUT-1:0]    led_q, led_d;

    always_comb begin
        cnt_d = cnt_q + PWM_BITS'(1);
        led_d = out_q & {N_OUT{cnt_q < duty_q}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            led_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign led_out = led_q;
`else
    localparam int unused_pwm_bits = PWM_BITS;
    assign led_out = out_q;
`endif

    always_comb begin
        rd_word = '0;
        case (bus_addr)
            ADDR_IN:   rd_word[N_IN-1:0]  = stable;
            ADDR_OUT:  rd_word[N_OUT-1:0] = out_q;
            ADDR_IEN:  rd_word[N_IN-1:0]  = irq_en_q;
            ADDR_PEND: rd_word[N_IN-1:0]  = pend_q;
`ifdef BOARD_GPIO_PWM_EN
            ADDR_PWM:  rd_word[PWM_BITS-1:0] = duty_q;
`endif
            default:   rd_word = '0;
        endcase
    end

    // Every access, mapped or not, gets exactly one ready pulse.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_sel) begin
                    state_d = S_READY;
                    rdata_d = rd_word;
                end
            end
            S_READY: begin
                state_d = S_IDLE;
                wr_en   = bus_sel & bus_write;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_d    = out_q;
        irq_en_d = irq_en_q;
        pend_clr = '0;
`ifdef BOARD_GPIO_PWM_EN
        duty_d   = duty_q;
`endif
        if (wr_en) begin
            case (bus_addr)
                ADDR_OUT:  out_d    = bus_wdata[N_OUT-1:0];
                ADDR_IEN:  irq_en_d = bus_wdata[N_IN-1:0];
                ADDR_PEND: pend_clr = bus_wdata[N_IN-1:0];
`ifdef BOARD_GPIO_PWM_EN
                ADDR_PWM:  duty_d   = bus_wdata[PWM_BITS-1:0];
`endif
                default: ;
            endcase
        end
        // A new edge beats a same-cycle clear of that bit.
        pend_d = (pend_q & ~pend_clr) | edge_det;
        irq_d  = |(pend_q & irq_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rdata_q  <= '0;
            out_q    <= '0;
            irq_en_q <= '0;
            pend_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            out_q    <= out_d;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
        end
    end

`ifdef BOARD_GPIO_PWM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) duty_q <= '1;
        else        duty_q <= duty_d;
    end
`endif

    assign bus_ready = (state_q == S_READY);
    assign bus_rdata = rdata_q;
    assign irq       = irq_q;

endmodule
